// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone definitions for the bus fabric.
//   CTI_* : cycle type identifier encodings (classic, constant, incrementing, end-of-burst)
//   arb_state_t : arbiter ownership state (idle / a master owns the bus)
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic {ARB_IDLE, ARB_OWNED} arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotate-priority encoder.
//   req      in  [N-1:0]  request vector
//   last_idx in  [W-1:0]  index of the previous owner (lowest priority)
//   valid    out          any request present
//   idx      out [W-1:0]  first requester scanning last_idx+1 .. last_idx+N (mod N)
module rr_pick #(
  parameter int unsigned N = 2,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_idx,
  output logic         valid,
  output logic [W-1:0] idx
);

  int unsigned cand;
  logic [W-1:0] cidx;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    cidx  = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = (32'(last_idx) + i) % N;
      cidx = W'(cand);
      if (!valid && req[cidx]) begin
        valid = 1'b1;
        idx   = cidx;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: N-master to 1-slave Wishbone B4 round-robin arbiter.
// The grant is held for the owner's whole CYC (bursts included); terminations
// are routed back to the owner only; read data is broadcast to every master.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   m_cyc/m_stb/m_we [N-1:0]       per-master request/strobe/write-enable
//   m_adr/m_dat_o/m_cti            per-master address, write data, cycle type
//   m_dat_i                        slave read data (unqualified broadcast)
//   m_ack/m_err/m_rty [N-1:0]      terminations to the owner only
//   s_cyc/s_stb/s_we/s_adr/s_dat_o/s_cti   to slave
//   s_dat_i, s_ack/s_err/s_rty     from slave
//   grant [N-1:0]                  one-hot owner, 0 when idle
// Optional: `define WB_ARB_TIMEOUT_EN adds a stall watchdog that answers ERR
// after TIMEOUT unterminated strobe cycles.
module wb_rr_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADR_W       = 32,
  parameter int unsigned DAT_W       = 32,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_MASTERS-1:0]             m_cyc,
  input  logic [NUM_MASTERS-1:0]             m_stb,
  input  logic [NUM_MASTERS-1:0]             m_we,
  input  logic [NUM_MASTERS-1:0][ADR_W-1:0]  m_adr,
  input  logic [NUM_MASTERS-1:0][DAT_W-1:0]  m_dat_o,
  input  logic [NUM_MASTERS-1:0][2:0]        m_cti,
  output logic [DAT_W-1:0]                   m_dat_i,
  output logic [NUM_MASTERS-1:0]             m_ack,
  output logic [NUM_MASTERS-1:0]             m_err,
  output logic [NUM_MASTERS-1:0]             m_rty,
  output logic                               s_cyc,
  output logic                               s_stb,
  output logic                               s_we,
  output logic [ADR_W-1:0]                   s_adr,
  output logic [DAT_W-1:0]                   s_dat_o,
  output logic [2:0]                         s_cti,
  input  logic [DAT_W-1:0]                   s_dat_i,
  input  logic                               s_ack,
  input  logic                               s_err,
  input  logic                               s_rty,
  output logic [NUM_MASTERS-1:0]             grant
);

  localparam int unsigned IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  arb_state_t fsm, fsm_nxt;
  logic [IW-1:0] grant_idx, grant_idx_nxt;
  logic [IW-1:0] last_idx, last_idx_nxt;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          owner_active;
  logic          wd_fire;

  rr_pick #(.N(NUM_MASTERS), .W(IW)) u_pick (
    .req      (m_cyc),
    .last_idx (last_idx),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= ARB_IDLE;
      grant_idx <= '0;
      last_idx  <= IW'(NUM_MASTERS - 1);
    end else begin
      fsm       <= fsm_nxt;
      grant_idx <= grant_idx_nxt;
      last_idx  <= last_idx_nxt;
    end
  end

  always_comb begin
    fsm_nxt       = fsm;
    grant_idx_nxt = grant_idx;
    last_idx_nxt  = last_idx;
    case (fsm)
      ARB_IDLE: begin
        if (pick_valid) begin
          fsm_nxt       = ARB_OWNED;
          grant_idx_nxt = pick_idx;
        end
      end
      ARB_OWNED: begin
        if (!m_cyc[grant_idx]) begin
          fsm_nxt      = ARB_IDLE;
          last_idx_nxt = grant_idx;
        end
      end
      default: fsm_nxt = ARB_IDLE;
    endcase
  end

  // Owner dropping CYC gates the slave side off in that same cycle, ahead of the FSM.
  assign owner_active = (fsm == ARB_OWNED) && m_cyc[grant_idx];
  assign m_dat_i      = s_dat_i;

  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_o = '0;
    s_cti   = '0;
    m_ack   = '0;
    m_err   = '0;
    m_rty   = '0;
    grant   = '0;
    if (fsm == ARB_OWNED) grant[grant_idx] = 1'b1;
    if (owner_active) begin
      s_cyc              = ~wd_fire;
      s_stb              = m_stb[grant_idx] & ~wd_fire;
      s_we               = m_we[grant_idx];
      s_adr              = m_adr[grant_idx];
      s_dat_o            = m_dat_o[grant_idx];
      s_cti              = m_cti[grant_idx];
      m_ack[grant_idx]   = s_ack & ~wd_fire;
      m_err[grant_idx]   = s_err | wd_fire;
      m_rty[grant_idx]   = s_rty & ~wd_fire;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt;
  logic          stall;

  // Stall is judged on the master's strobe, not the gated s_stb, so the fire cycle itself clears.
  assign stall   = owner_active & m_stb[grant_idx] & ~(s_ack | s_err | s_rty);
  assign wd_fire = owner_active & (wd_cnt == CW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst || !stall || wd_fire) wd_cnt <= '0;
    else                          wd_cnt <= wd_cnt + CW'(1);
  end
`else
  logic timeout_unused;
  assign wd_fire        = 1'b0;
  assign timeout_unused = (TIMEOUT != 0);
`endif

endmodule
